// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode encoding and round-robin pointer helper for rr_stream_mux
package stream_mux_pkg;

    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;

    function automatic int next_ptr(input int g, input int n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter: round-robin grant over a request vector, starting the search at the held pointer
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_CH-1:0]  i_req,
    input  logic             i_advance,
    output logic [N_CH-1:0]  o_gnt,
    output logic [SEL_W-1:0] o_gnt_idx,
    output logic             o_gnt_valid
);

    logic [SEL_W-1:0] ptr;
    int               idx;

    // Walk offsets from highest to lowest so the nearest request above ptr wins.
    always_comb begin
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        idx         = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_CH;
            if (i_req[idx]) begin
                o_gnt_idx   = SEL_W'(idx);
                o_gnt_valid = 1'b1;
            end
        end
    end

    assign o_gnt = o_gnt_valid ? (N_CH'(1) << o_gnt_idx) : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ptr <= '0;
        else if (i_advance)
            ptr <= SEL_W'(next_ptr(int'(o_gnt_idx), N_CH));
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N:1 valid/ready stream mux with fixed or round-robin selection and a registered output
module rr_stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 2,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_mode,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [N_CH-1:0]         i_valid,
    input  logic [N_CH*WIDTH-1:0]   i_data,
    output logic [N_CH-1:0]         o_ready,
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
    output logic [SEL_W-1:0]        o_ch,
    input  logic                    i_ready
);

    mux_mode_e        mode;
    logic             load, fixed_gv, rr_gv, gnt_valid, xfer;
    logic [SEL_W-1:0] rr_idx, gnt_idx;
    logic [N_CH-1:0]  rr_gnt, fixed_gnt;

    assign mode      = mux_mode_e'(i_mode);
    assign load      = !o_valid || i_ready;
    // An out-of-range select (non power-of-two N_CH) never grants.
    assign fixed_gv  = (int'(i_sel) < N_CH) && i_valid[i_sel];
    assign fixed_gnt = fixed_gv ? (N_CH'(1) << i_sel) : '0;
    assign gnt_valid = (mode == MODE_RR) ? rr_gv : fixed_gv;
    assign gnt_idx   = (mode == MODE_RR) ? rr_idx : i_sel;
    assign xfer      = load && gnt_valid;
    assign o_ready   = (i_rst_n && load) ? ((mode == MODE_RR) ? rr_gnt : fixed_gnt) : '0;

    rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_valid),
        .i_advance   (xfer && mode == MODE_RR),
        .o_gnt       (rr_gnt),
        .o_gnt_idx   (rr_idx),
        .o_gnt_valid (rr_gv)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
        end else if (load) begin
            o_valid <= gnt_valid;
            if (gnt_valid) begin
                o_data <= i_data[int'(gnt_idx)*WIDTH +: WIDTH];
                o_ch   <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed scenarios plus random traffic against a behavioural model of the mux
module tb_rr_stream_mux;
    import stream_mux_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] valid = '0;
    logic [7:0] data = 8'b11_10_01_00;
    logic [3:0] o_ready;
    logic       o_valid;
    logic [1:0] o_data;
    logic [1:0] o_ch;
    logic       ready = 1'b0;

    int n_checks = 0;
    int n_errs = 0;
    bit m_valid = 0;
    int m_data = 0;
    int m_ch = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    rr_stream_mux #(.N_CH(4), .WIDTH(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_mode  (mode),
        .i_sel   (sel),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .i_ready (ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of traffic: model predicts ready before the edge and the output register after it.
    task automatic cycle(input logic m, input int s, input logic [3:0] v, input logic r);
        int         g;
        bit         gv;
        bit         ld;
        logic [3:0] er;
        mode = m;
        sel = 2'(s);
        valid = v;
        ready = r;
        gv = 0;
        g = 0;
        if (!m) begin
            if (v[s]) begin gv = 1; g = s; end
        end else begin
            for (int k = 0; k < 4; k++)
                if (!gv && v[(m_ptr + k) % 4]) begin gv = 1; g = (m_ptr + k) % 4; end
        end
        ld = !m_valid || r;
        er = (ld && gv) ? 4'(1 << g) : 4'b0;
        #1 check("ready", int'(o_ready), int'(er));
        @(posedge clk);
        if (ld) begin
            m_valid = gv;
            if (gv) begin
                m_data = int'(data[g*2 +: 2]);
                m_ch = g;
                if (m) m_ptr = next_ptr(g, 4);
            end
        end
        #1;
        check("valid", int'(o_valid), int'(m_valid));
        check("data", int'(o_data), m_data);
        check("ch", int'(o_ch), m_ch);
    endtask

    initial begin
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_ch", int'(o_ch), 0);
        check("rst_ready", int'(o_ready), 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 4; s++) begin
            cycle(MODE_FIXED, s, 4'b1111, 1'b1);
            check("t1_data", int'(o_data), s);
        end
        for (int k = 0; k < 8; k++) begin
            cycle(MODE_RR, 0, 4'b1111, 1'b1);
            check("t2_ch", int'(o_ch), k % 4);
            check("t2_valid", int'(o_valid), 1);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(MODE_RR, 0, 4'b1010, 1'b1);
            check("t3_ch", int'(o_ch), (k % 2) ? 3 : 1);
        end
        cycle(MODE_RR, 0, 4'b1111, 1'b1);
        check("t4_first", int'(o_ch), 0);
        for (int k = 0; k < 3; k++) begin
            cycle(MODE_RR, 0, 4'b1111, 1'b0);
            check("t4_hold_ch", int'(o_ch), 0);
            check("t4_hold_ready", int'(o_ready), 0);
        end
        cycle(MODE_RR, 0, 4'b1111, 1'b1);
        check("t4_resume", int'(o_ch), 1);
        cycle(MODE_FIXED, 2, 4'b1011, 1'b1);
        cycle(MODE_FIXED, 2, 4'b1011, 1'b1);
        check("t5_nogrant", int'(o_valid), 0);
        cycle(MODE_FIXED, 2, 4'b1111, 1'b1);
        check("t5_data", int'(o_data), 2);
        for (int k = 0; k < 300; k++) begin
            data = 8'($urandom);
            cycle(1'($urandom), int'($urandom_range(0, 3)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        data = 8'b11_10_01_00;
        cycle(MODE_RR, 0, 4'b0110, 1'b0);
        cycle(MODE_RR, 0, 4'b0110, 1'b0);
        check("t6_pre", int'(o_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", int'(o_valid), 0);
        check("t6_data", int'(o_data), 0);
        check("t6_ready", int'(o_ready), 0);
        m_valid = 0;
        m_data = 0;
        m_ch = 0;
        m_ptr = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        cycle(MODE_RR, 0, 4'b1111, 1'b1);
        check("t6_first", int'(o_ch), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
